transfer_scheduler: RTL and testbench
=====================================

# transfer_scheduler

Sequences frame readout for the masking datapath. Assigns image rows to `NUM_LANES` transfer lanes and shares the single frame-buffer read port between them round-robin, one pixel read per cycle. Returns each pixel tagged with its destination lane, row and column, and signals frame completion. Sits between the frame-buffer memory and the bank of per-row transfer lanes.

## Interface
- `NUM_LANES`, 4: number of transfer lanes served.
- `COL_LEN`, 640: pixels per row.
- `ROW_COUNT`, 480: rows per frame.
- `PIX_W`, 12: pixel width.
- `ADDR_W`, 19: frame-buffer address width.
- `Clock  in  1  system clock, rising edge`
- `nReset  in  1  asynchronous, active-low reset`
- `start  in  1  single-cycle pulse: begin one frame; ignored while busy`
- `busy  out  1  frame in progress`
- `done  out  1  single-cycle pulse: last pixel delivered`
- `lane_ready  in  NUM_LANES  lane can accept pixels`
- `lane_active  out  NUM_LANES  lane holds an assigned row`
- `lane_row  out  NUM_LANES*9  row currently assigned to each lane, lane 0 in LSBs`
- `mem_en  out  1  read strobe`
- `mem_addr  out  ADDR_W  read address`
- `mem_data  in  PIX_W  read data, valid the cycle after mem_en`
- `pixel_data  out  PIX_W  mem_data passed through`
- `pixel_valid  out  NUM_LANES  one-hot destination of pixel_data`
- `pixel_row  out  9  row of pixel_data`
- `pixel_col  out  10  column of pixel_data`

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE + start: lane i gets row i where i < ROW_COUNT; lanes without a row stay inactive. next_row = min(NUM_LANES, ROW_COUNT). Go to RUN.
- RUN, each cycle:
  - Eligible = lane_active & lane_ready.
  - Round-robin pick, searching upward from the lane after the last grant.
  - Issue one read at base[lane] + col[lane].
  - base[lane] = row*COL_LEN, held incrementally (add COL_LEN per assignment). No multiplier.
  - When col reaches COL_LEN-1, the row is complete and col wraps to 0.
  - On row completion, if next_row < ROW_COUNT: assign next_row to that lane in the same edge and increment next_row. Otherwise clear lane_active.
  - Only one lane can complete per cycle, so next_row advances at most once per cycle.
- When the final read issues (no lane active afterwards), go to DRAIN.
- DRAIN: deliver the last pixel, pulse done, go to IDLE.
- No eligible lane: mem_en = 0, pointer unchanged.
- Lanes must absorb up to 2 pixels already in flight after dropping lane_ready.
- start while busy: ignored. start coincident with nReset low: ignored.

## Timing
- Grant decided in cycle t. mem_en, mem_addr and the internal grant register update at edge t+1.
- pixel_valid, pixel_row and pixel_col are registered one cycle after mem_en. pixel_data = mem_data, combinational.
- start to first mem_en: 2 cycles (assign edge, then first grant edge).
- Full throughput when lanes are ready: one mem_en per cycle, ROW_COUNT*COL_LEN consecutive reads.
- done is asserted in the same cycle as the final pixel_valid. busy drops the next cycle.
- busy is high from the edge after start through the done cycle.
- Reset values: all outputs 0; state IDLE; pointer 0; next_row 0.
- nReset low mid-frame: all of the following clear immediately:
  - state,
  - lane assignments,
  - in-flight pixel_valid.
  
  The returning mem_data is discarded.

## Structure
- Shared constants in the common include: COL_LEN, ROW_COUNT, PIX_W, ADDR_W, row width 9, column width 10.
- One sub-module: `rr_arbiter`. It is parameterised by NUM_LANES, takes a request vector and an advance enable, and outputs a one-hot grant. Its pointer updates only on a grant.
- Row assignment, address generation and the FSM stay in `transfer_scheduler`.

## Test plan
1. Assert nReset, then release with no start: all outputs 0, busy 0, no mem_en for 20 cycles.
2. COL_LEN=4, ROW_COUNT=6, NUM_LANES=2, all ready, start: 24 back-to-back mem_en.
   - Addresses 0,4,1,5,2,6,3,7,8,12,…
   - Lane 0 rows 0,2,4; lane 1 rows 1,3,5.
   - pixel_valid alternates 01/10 one cycle behind mem_en.
   - done coincides with the 24th pixel_valid.
3. Same config, lane_ready[1] held 0:
   - Lane 0 reads rows 0,2,3,4,5 (20 reads), then mem_en stays 0.
   - Raising lane_ready[1] gives addresses 4–7, then done.
4. ROW_COUNT=1, NUM_LANES=2: lane_active = 01 throughout; 4 reads at addresses 0–3; done 1 cycle after the last mem_en.
5. Toggle lane_ready[0] every cycle with lane 1 always ready: grants never go to a not-ready lane, order stays round-robin, and every address 0–23 is read exactly once.
6. start while busy → ignored; nReset pulse mid-row → outputs 0 immediately, no pixel_valid for the in-flight read, and a fresh start restarts at address 0.

Source files
------------

// File: rtl/transfer_scheduler_pkg.sv
// Shared frame geometry, field widths and FSM state type for the transfer scheduler.
package transfer_scheduler_pkg;

    localparam int unsigned COL_LEN   = 640;
    localparam int unsigned ROW_COUNT = 480;
    localparam int unsigned PIX_W     = 12;
    localparam int unsigned ADDR_W    = 19;
    localparam int unsigned ROW_W     = 9;
    localparam int unsigned COL_W     = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/transfer_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the lane after the last grant.
module rr_arbiter #(
    parameter int unsigned NUM_LANES = 4
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [NUM_LANES-1:0] req,
    input  logic                 advance,
    output logic [NUM_LANES-1:0] grant
);

    localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        ptr_d = ptr_q;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_LANES) begin
                idx = idx - NUM_LANES;
            end
            if (grant == '0 && req[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                ptr_d = (idx + 1 == NUM_LANES) ? '0 : IDX_W'(idx + 1);
            end
        end
    end

    // Pointer holds when nothing is granted so idle cycles do not skew fairness.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/transfer_scheduler.sv
// Frame readout sequencer: hands rows to transfer lanes and shares one frame-buffer read port.
module transfer_scheduler #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned COL_LEN   = transfer_scheduler_pkg::COL_LEN,
    parameter int unsigned ROW_COUNT = transfer_scheduler_pkg::ROW_COUNT,
    parameter int unsigned PIX_W     = transfer_scheduler_pkg::PIX_W,
    parameter int unsigned ADDR_W    = transfer_scheduler_pkg::ADDR_W
) (
    input  logic                                              Clock,
    input  logic                                              nReset,
    input  logic                                              start,
    output logic                                              busy,
    output logic                                              done,
    input  logic [NUM_LANES-1:0]                              lane_ready,
    output logic [NUM_LANES-1:0]                              lane_active,
    output logic [NUM_LANES*transfer_scheduler_pkg::ROW_W-1:0] lane_row,
    output logic                                              mem_en,
    output logic [ADDR_W-1:0]                                 mem_addr,
    input  logic [PIX_W-1:0]                                  mem_data,
    output logic [PIX_W-1:0]                                  pixel_data,
    output logic [NUM_LANES-1:0]                              pixel_valid,
    output logic [transfer_scheduler_pkg::ROW_W-1:0]          pixel_row,
    output logic [transfer_scheduler_pkg::COL_W-1:0]          pixel_col
);

    import transfer_scheduler_pkg::*;

    localparam int unsigned IDX_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned FIRST_ROWS = (NUM_LANES < ROW_COUNT) ? NUM_LANES : ROW_COUNT;
    localparam logic [ROW_W:0]      ROW_LIMIT  = (ROW_W + 1)'(ROW_COUNT);
    localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(COL_LEN - 1);
    localparam logic [ADDR_W-1:0]   ROW_STRIDE = ADDR_W'(COL_LEN);

    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mem_en_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [NUM_LANES-1:0]  active_q;
    logic [NUM_LANES-1:0]  grant_q;
    logic [NUM_LANES-1:0]  pixel_valid_q;
    logic [ROW_W-1:0]      row_q  [NUM_LANES];
    logic [COL_W-1:0]      col_q  [NUM_LANES];
    logic [ADDR_W-1:0]     base_q [NUM_LANES];
    logic [ROW_W:0]        next_row_q;
    logic [ADDR_W-1:0]     next_base_q;
    logic [ROW_W-1:0]      iss_row_q;
    logic [COL_W-1:0]      iss_col_q;
    logic [ROW_W-1:0]      pixel_row_q;
    logic [COL_W-1:0]      pixel_col_q;

    logic [NUM_LANES-1:0]  req;
    logic [NUM_LANES-1:0]  grant;
    logic [IDX_W-1:0]      gidx;
    logic                  running;
    logic                  any_grant;
    logic                  row_done;
    logic                  refill;
    logic                  last_read;

    assign running = (state_q == StRun);
    assign req     = running ? (active_q & lane_ready) : '0;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_arb (
        .Clock   (Clock),
        .nReset  (nReset),
        .req     (req),
        .advance (running),
        .grant   (grant)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (grant[i]) begin
                gidx = IDX_W'(i);
            end
        end
    end

    assign any_grant = |grant;
    assign row_done  = (col_q[gidx] == COL_LAST);
    assign refill    = (next_row_q < ROW_LIMIT);
    // Final read: the granted lane finishes its row, no rows remain, no other lane holds one.
    assign last_read = any_grant && row_done && !refill && ((active_q & ~grant) == '0);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            active_q      <= '0;
            grant_q       <= '0;
            pixel_valid_q <= '0;
            next_row_q    <= '0;
            next_base_q   <= '0;
            iss_row_q     <= '0;
            iss_col_q     <= '0;
            pixel_row_q   <= '0;
            pixel_col_q   <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                row_q[i]  <= '0;
                col_q[i]  <= '0;
                base_q[i] <= '0;
            end
        end else begin
            done_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            pixel_valid_q <= mem_en_q ? grant_q : '0;
            if (mem_en_q) begin
                pixel_row_q <= iss_row_q;
                pixel_col_q <= iss_col_q;
            end
            if (done_q) begin
                busy_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (start && !busy_q) begin
                        for (int unsigned i = 0; i < NUM_LANES; i++) begin
                            active_q[i] <= (i < ROW_COUNT);
                            row_q[i]    <= ROW_W'(i);
                            col_q[i]    <= '0;
                            base_q[i]   <= ADDR_W'(i * COL_LEN);
                        end
                        next_row_q  <= (ROW_W + 1)'(FIRST_ROWS);
                        next_base_q <= ADDR_W'(FIRST_ROWS * COL_LEN);
                        busy_q      <= 1'b1;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (any_grant) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= base_q[gidx] + ADDR_W'(col_q[gidx]);
                        grant_q    <= grant;
                        iss_row_q  <= row_q[gidx];
                        iss_col_q  <= col_q[gidx];
                        if (row_done) begin
                            col_q[gidx] <= '0;
                            // next_base tracks next_row*COL_LEN so no multiplier is needed.
                            if (refill) begin
                                row_q[gidx]  <= next_row_q[ROW_W-1:0];
                                base_q[gidx] <= next_base_q;
                                next_row_q   <= next_row_q + (ROW_W + 1)'(1);
                                next_base_q  <= next_base_q + ROW_STRIDE;
                            end else begin
                                active_q[gidx] <= 1'b0;
                            end
                        end else begin
                            col_q[gidx] <= col_q[gidx] + COL_W'(1);
                        end
                        if (last_read) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        lane_row = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_row[i*ROW_W +: ROW_W] = row_q[i];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign lane_active = active_q;
    assign mem_en      = mem_en_q;
    assign mem_addr    = mem_addr_q;
    assign pixel_data  = mem_data;
    assign pixel_valid = pixel_valid_q;
    assign pixel_row   = pixel_row_q;
    assign pixel_col   = pixel_col_q;

endmodule

// File: tb/tb_transfer_scheduler.sv
// Randomized scoreboard bench for transfer_scheduler on a 2-lane, 6x4 frame plus a 1-row frame.
module tb_transfer_scheduler;

    localparam int unsigned NL = 2;
    localparam int unsigned CL = 4;
    localparam int unsigned RC = 6;
    localparam int unsigned PW = 12;
    localparam int unsigned AW = 19;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic          start, busy, done, mem_en;
    logic [NL-1:0] lane_ready, lane_active, pixel_valid;
    logic [NL*9-1:0] lane_row;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_data = '0;
    logic [PW-1:0] pixel_data;
    logic [8:0]    pixel_row;
    logic [9:0]    pixel_col;

    logic          start1, busy1, done1, mem_en1;
    logic [1:0]    lane_ready1, lane_active1, pixel_valid1;
    logic [17:0]   lane_row1;
    logic [AW-1:0] mem_addr1;
    logic [PW-1:0] mem_data1;
    logic [PW-1:0] pixel_data1;
    logic [8:0]    pixel_row1;
    logic [9:0]    pixel_col1;

    always #5 Clock = ~Clock;

    transfer_scheduler #(
        .NUM_LANES(NL), .COL_LEN(CL), .ROW_COUNT(RC), .PIX_W(PW), .ADDR_W(AW)
    ) dut (
        .Clock(Clock), .nReset(nReset), .start(start), .busy(busy), .done(done),
        .lane_ready(lane_ready), .lane_active(lane_active), .lane_row(lane_row),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_row(pixel_row), .pixel_col(pixel_col)
    );

    transfer_scheduler #(
        .NUM_LANES(2), .COL_LEN(4), .ROW_COUNT(1), .PIX_W(PW), .ADDR_W(AW)
    ) dut1 (
        .Clock(Clock), .nReset(nReset), .start(start1), .busy(busy1), .done(done1),
        .lane_ready(lane_ready1), .lane_active(lane_active1), .lane_row(lane_row1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .pixel_data(pixel_data1), .pixel_valid(pixel_valid1),
        .pixel_row(pixel_row1), .pixel_col(pixel_col1)
    );

    typedef struct {
        int unsigned lane;
        int unsigned row;
        int unsigned col;
        int unsigned addr;
        bit          last;
    } pix_t;

    int unsigned addr_q[$];
    pix_t        pix_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    // Reference model state: what each lane holds, in plain row/column terms.
    bit          m_run = 1'b0;
    bit          m_active[NL];
    int unsigned m_row[NL];
    int unsigned m_col[NL];
    int unsigned m_next;
    int unsigned m_ptr = 0;

    bit          first_seen, got_done, prev_done = 1'b0;
    int unsigned first_en_cyc, last_en_cyc, start_cyc, dut_reads;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [PW-1:0] pix_of(input int unsigned a);
        return PW'(a * 13 + 5);
    endfunction

    always @(posedge Clock) if (mem_en) mem_data <= pix_of(32'(mem_addr));
    assign mem_data1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got an output event, expected none", name);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_start();
        for (int l = 0; l < NL; l++) begin
            m_active[l] = (l < RC);
            m_row[l]    = l;
            m_col[l]    = 0;
        end
        m_next = (NL < RC) ? NL : RC;
        m_run  = 1'b1;
    endtask

    task automatic model_step(input logic [NL-1:0] rdy, output bit granted);
        int   g;
        pix_t p;
        bit   any;
        g = -1;
        for (int k = 0; k < NL; k++) begin
            int l;
            l = (m_ptr + k) % NL;
            if (g < 0 && m_active[l] && rdy[l]) g = l;
        end
        granted = (g >= 0);
        if (!granted) return;
        p.lane = g;
        p.row  = m_row[g];
        p.col  = m_col[g];
        p.addr = m_row[g] * CL + m_col[g];
        m_col[g]++;
        if (m_col[g] == CL) begin
            m_col[g] = 0;
            if (m_next < RC) begin
                m_row[g] = m_next;
                m_next++;
            end else begin
                m_active[g] = 1'b0;
            end
        end
        m_ptr = (g + 1) % NL;
        any = 1'b0;
        for (int l = 0; l < NL; l++) any |= m_active[l];
        p.last = !any;
        if (p.last) m_run = 1'b0;
        addr_q.push_back(p.addr);
        pix_q.push_back(p);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read or a pixel.
    always @(negedge Clock) begin
        if (nReset) begin
            if (prev_done) check("busy_after_done", busy, 0);
            prev_done = done;
            if (mem_en) begin
                dut_reads++;
                if (!first_seen) begin
                    first_seen   = 1'b1;
                    first_en_cyc = cyc;
                end
                last_en_cyc = cyc;
                if (addr_q.size() == 0) fail("unexpected_mem_en");
                else check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (pixel_valid != '0 || done) begin
                if (pix_q.size() == 0) begin
                    fail("unexpected_pixel");
                end else begin
                    pix_t          p;
                    logic [NL-1:0] exp_pv;
                    p = pix_q.pop_front();
                    exp_pv = '0;
                    exp_pv[p.lane] = 1'b1;
                    check("pixel_valid", pixel_valid, exp_pv);
                    check("pixel_row", pixel_row, p.row);
                    check("pixel_col", pixel_col, p.col);
                    check("pixel_data", pixel_data, pix_of(p.addr));
                    check("done_on_last", done, p.last);
                    if (done) begin
                        got_done = 1'b1;
                        check("busy_in_done_cycle", busy, 1);
                        check("done_after_last_mem_en", cyc - last_en_cyc, 1);
                    end
                end
            end
        end
    end

    // mode 0: all ready; 1: lane 1 held off until lane 0 runs dry; 2: lane 0 toggles; 3: random.
    task automatic run_frame(input int mode, input int rst_at);
        bit            granted;
        int            idle;
        logic [NL-1:0] rdy;
        first_seen = 1'b0;
        got_done   = 1'b0;
        dut_reads  = 0;
        idle       = 0;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start = 1'b0;
        model_start();
        check("busy_after_start", busy, 1);
        check("lane_active_init", lane_active, 2'b11);
        check("lane_row_init", lane_row, {9'd1, 9'd0});
        for (int c = 0; c < 800 && m_run; c++) begin
            case (mode)
                0:       rdy = 2'b11;
                1:       rdy = (idle >= 5) ? 2'b11 : 2'b01;
                2:       rdy = {1'b1, 1'(c % 2)};
                default: rdy = 2'($urandom_range(0, 3));
            endcase
            lane_ready = rdy;
            start      = (mode == 3 && c == 10);
            if (c == rst_at) begin
                nReset = 1'b0;
                #1;
                check("reset_busy", busy, 0);
                check("reset_mem_en", mem_en, 0);
                check("reset_pixel_valid", pixel_valid, 0);
                check("reset_lane_active", lane_active, 0);
                check("reset_done", done, 0);
                addr_q.delete();
                pix_q.delete();
                m_run      = 1'b0;
                m_ptr      = 0;
                prev_done  = 1'b0;
                start      = 1'b0;
                lane_ready = '0;
                tick();
                tick();
                nReset = 1'b1;
                tick();
                return;
            end
            model_step(rdy, granted);
            if (!granted) begin
                idle++;
                if (mode == 1 && idle == 5) check("lane0_only_reads", dut_reads, 20);
            end
            tick();
        end
        start = 1'b0;
        for (int c = 0; c < 10 && !got_done; c++) tick();
        check("done_seen", got_done, 1);
        check("scoreboard_drained", addr_q.size() + pix_q.size(), 0);
        check("start_to_first_mem_en", first_en_cyc - start_cyc, 2);
        check("reads_per_frame", dut_reads, RC * CL);
        if (mode == 0) check("back_to_back_reads", last_en_cyc - first_en_cyc, RC * CL - 1);
        tick();
        tick();
    endtask

    initial begin
        int unsigned n1, last1;
        bit          d1;
        start       = 1'b0;
        start1      = 1'b0;
        lane_ready  = '0;
        lane_ready1 = 2'b11;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_outputs", {busy, done, mem_en, pixel_valid, lane_active, mem_addr,
                                pixel_row, pixel_col}, 0);
        check("reset_lane_row", lane_row, 0);
        nReset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_quiet", {busy, done, mem_en, pixel_valid, lane_active, mem_addr,
                                 busy1, mem_en1, lane_active1}, 0);
        end

        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);
        repeat (3) run_frame(3, -1);
        run_frame(0, 7);
        run_frame(0, -1);

        n1     = 0;
        last1  = 0;
        d1     = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge Clock);
            if (busy1) check("one_row_lane1_idle", lane_active1[1], 0);
            if (mem_en1) begin
                if (n1 < 3) check("one_row_lane_active", lane_active1, 2'b01);
                check("one_row_addr", mem_addr1, n1);
                n1++;
                last1 = cyc;
            end
            if (done1) begin
                d1 = 1'b1;
                check("one_row_done_latency", cyc - last1, 1);
            end
        end
        check("one_row_reads", n1, 4);
        check("one_row_done_seen", d1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
